instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch/issue sequencer. It is the producer side of the control unit's opcode interface.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and latches each one into an instruction register.
- Presents the opcode (op) and an issue strobe (en) to the control unit, then waits for the control unit to finish executing.
- Advances the PC sequentially, or loads a branch target when the control unit asserts pc_sel.

Parameters:
- ADDR_W, 16: PC and instruction-memory address width.
- INSTR_W, 16: instruction width. The opcode is instr[INSTR_W-1:INSTR_W-4].
- RESET_PC, 0: PC value after reset.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- run, input, 1: level. While high, the sequencer keeps fetching.
- imem_req, output, 1: fetch request to instruction memory.
- imem_addr, output, ADDR_W: fetch address. Equals pc while imem_req is high.
- imem_rdata, input, INSTR_W: instruction word. Valid only in the cycle imem_ack is high.
- imem_ack, input, 1: memory accepts the request and returns data in the same cycle.
- op, output, 4: opcode to the control unit (drives its OP input).
- operand, output, INSTR_W-4: low instruction field (register/immediate bits).
- en, output, 1: one-cycle issue strobe to the control unit.
- exec_done, input, 1: control unit has finished the current instruction.
- pc_sel, input, 1: sampled with exec_done. 1 selects pc_target as the next PC.
- pc_target, input, ADDR_W: branch/jump target.
- pc, output, ADDR_W: current PC.
- busy, output, 1: high in every state except IDLE.
- halted, output, 1: halt indicator. Tied 0 unless FETCH_HALT_EN is defined.

Behaviour:
- Reset values (rst sampled high on a clock edge): state=IDLE, pc=RESET_PC, ir=0, op=0, operand=0, en=0, imem_req=0, busy=0, halted=0.
  - rst overrides everything, including mid-handshake. imem_req drops in the following cycle.
- FSM states: IDLE, FETCH, ISSUE, EXEC.
- IDLE:
  - Outputs are quiet.
  - run=1 -> FETCH on the next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Request and address are held stable until imem_ack.
  - On the ack cycle: ir <= imem_rdata, next state ISSUE.
  - Minimum fetch latency is 1 cycle (ack in the first FETCH cycle). There is no upper bound.
- ISSUE:
  - en=1 for exactly this one cycle.
  - op=ir[15:12] and operand=ir[11:0] are valid from the ISSUE cycle until the next ir load.
  - exec_done=1 in the ISSUE cycle is accepted as single-cycle completion and is handled as in EXEC.
  - Otherwise the next state is EXEC.
- EXEC:
  - en=0. Wait for exec_done.
  - On exec_done: pc <= pc_sel ? pc_target : pc+1. pc+1 wraps modulo 2^ADDR_W (0xFFFF -> 0x0000).
  - Then go to FETCH if run=1, else IDLE.
- run deasserted mid-instruction: the current instruction completes (fetch, issue, PC update), then the FSM goes to IDLE. No request is abandoned.
- exec_done or pc_sel outside ISSUE/EXEC: ignored.
- imem_ack outside FETCH: ignored.
- Issue period: one instruction per at least 2 cycles (FETCH+ISSUE with single-cycle exec).

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - Opcode 4'hF is HALT.
  - It is still issued (en pulse) and its exec_done is still awaited.
  - pc then holds at the HALT address + 1, halted=1, and the FSM sits in IDLE regardless of run.
  - Only rst clears halted.
- Not defined:
  - 4'hF is an ordinary opcode and halted is constant 0.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, EXEC=2'd3.
  - OP_HALT=4'hF.
  - The opcode field position constants.
- Sub-module: pc_reg, the PC register with synchronous reset, increment/load mux, and wrap. It is the natural split.
- The FSM and instruction register stay in instr_fetch.

Test Plan:
- Reset, then run=1, memory acks immediately, word 0x1234 at address 0 -> imem_addr=0; op=4'h1 and operand=0x234 from the next cycle; en high for one cycle; after exec_done, pc=1 and FETCH of address 1.
- Memory acks 3 cycles late -> imem_req and imem_addr held stable for 3 cycles; exactly one en pulse per instruction.
- exec_done with pc_sel=1, pc_target=0x0040 -> next imem_addr=0x0040. Also pc=0xFFFF with sequential completion -> pc=0x0000.
- run dropped during FETCH -> instruction still issued and pc incremented, then IDLE with busy=0 and imem_req=0.
- rst pulsed while in EXEC -> next cycle pc=RESET_PC, en=0, imem_req=0, state IDLE.
- With FETCH_HALT_EN defined, word 0xF000 at address 5 -> en pulse, then halted=1 and pc=6; run=1 causes no further imem_req; rst clears halted. Without the macro, the same word is issued normally and fetching continues.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared state encoding and opcode field constants for the fetch sequencer
package instr_fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        EXEC  = 2'd3
    } state_e;
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory handshake plus the opcode issue link to the control unit
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic                    imem_req;
    logic [ADDR_W-1:0]       imem_addr;
    logic [INSTR_W-1:0]      imem_rdata;
    logic                    imem_ack;
    logic [OP_W-1:0]         op;
    logic [INSTR_W-OP_W-1:0] operand;
    logic                    en;
    logic                    exec_done;
    logic                    pc_sel;
    logic [ADDR_W-1:0]       pc_target;
    modport master (
        output imem_req, imem_addr, op, operand, en,
        input  imem_rdata, imem_ack, exec_done, pc_sel, pc_target
    );
    modport slave (
        input  imem_req, imem_addr, op, operand, en,
        output imem_rdata, imem_ack, exec_done, pc_sel, pc_target
    );
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg: program counter with sequential increment (wrapping) or branch-target load
module pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    always_comb begin
        pc_d = adv ? (load ? target : pc_q + 1'b1) : pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end
    assign pc = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch/issue sequencer feeding the control unit; FETCH_HALT_EN makes opcode 4'hF a sticky HALT
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);
    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 halted_q, halted_d;
    logic                 done;
    logic                 is_halt;
    always_comb begin
        done = (state_q == ISSUE || state_q == EXEC) && bus.exec_done;
`ifdef FETCH_HALT_EN
        is_halt = ir_q[INSTR_W-1 -: OP_W] == OP_HALT;
`else
        is_halt = 1'b0;
`endif
        ir_d     = (state_q == FETCH && bus.imem_ack) ? bus.imem_rdata : ir_q;
        halted_d = halted_q | (done & is_halt);
        state_d  = state_q;
        case (state_q)
            IDLE:        state_d = (run && !halted_q) ? FETCH : IDLE;
            FETCH:       state_d = bus.imem_ack ? ISSUE : FETCH;
            ISSUE, EXEC: state_d = done ? ((run && !is_halt) ? FETCH : IDLE) : EXEC;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end
    // a HALT always resumes at its own address + 1, so branch loads are masked
    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .adv    (done),
        .load   (bus.pc_sel && !is_halt),
        .target (bus.pc_target),
        .pc     (pc)
    );
    assign bus.imem_req  = state_q == FETCH;
    assign bus.imem_addr = pc;
    assign bus.en        = state_q == ISSUE;
    assign bus.op        = ir_q[INSTR_W-1 -: OP_W];
    assign bus.operand   = ir_q[INSTR_W-OP_W-1:0];
    assign busy          = state_q != IDLE;
    assign halted        = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch, both with and without FETCH_HALT_EN
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] pc;
    logic        busy;
    logic        halted;
    int          errors = 0;
    int          checks = 0;
    instr_fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
    instr_fetch dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .bus    (bus),
        .pc     (pc),
        .busy   (busy),
        .halted (halted)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        run = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.exec_done = 1'b0;
        bus.pc_sel = 1'b0;
        bus.pc_target = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_req", 16'(bus.imem_req), 16'd0);
        chk("rst_en", 16'(bus.en), 16'd0);
        chk("rst_op", 16'(bus.op), 16'd0);
        chk("rst_operand", 16'(bus.operand), 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_halted", 16'(halted), 16'd0);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        chk("f0_req", 16'(bus.imem_req), 16'd1);
        chk("f0_addr", bus.imem_addr, 16'h0000);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h1234;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("i0_en", 16'(bus.en), 16'd1);
        chk("i0_op", 16'(bus.op), 16'h1);
        chk("i0_operand", 16'(bus.operand), 16'h234);
        @(negedge clk);
        chk("e0_en", 16'(bus.en), 16'd0);
        chk("e0_busy", 16'(busy), 16'd1);
        chk("e0_req", 16'(bus.imem_req), 16'd0);
        chk("e0_op", 16'(bus.op), 16'h1);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("seq_pc", pc, 16'h0001);
        chk("seq_req", 16'(bus.imem_req), 16'd1);
        chk("seq_addr", bus.imem_addr, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            chk("late_req", 16'(bus.imem_req), 16'd1);
            chk("late_addr", bus.imem_addr, 16'h0001);
            chk("late_en", 16'(bus.en), 16'd0);
            @(negedge clk);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h2ABC;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("i1_en", 16'(bus.en), 16'd1);
        chk("i1_op", 16'(bus.op), 16'h2);
        chk("i1_operand", 16'(bus.operand), 16'hABC);
        bus.exec_done = 1'b1;
        bus.pc_sel = 1'b1;
        bus.pc_target = 16'h0040;
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.pc_sel = 1'b0;
        chk("br_en_once", 16'(bus.en), 16'd0);
        chk("br_addr", bus.imem_addr, 16'h0040);
        chk("br_pc", pc, 16'h0040);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h3000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.exec_done = 1'b1;
        bus.pc_sel = 1'b1;
        bus.pc_target = 16'hFFFF;
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.pc_sel = 1'b0;
        chk("top_addr", bus.imem_addr, 16'hFFFF);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h4111;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("top_op", 16'(bus.op), 16'h4);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_addr", bus.imem_addr, 16'h0000);
        chk("wrap_req", 16'(bus.imem_req), 16'd1);
        run = 1'b0;
        @(negedge clk);
        chk("stop_req", 16'(bus.imem_req), 16'd1);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h5000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("stop_en", 16'(bus.en), 16'd1);
        chk("stop_op", 16'(bus.op), 16'h5);
        @(negedge clk);
        chk("stop_busy_exec", 16'(busy), 16'd1);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("stop_pc", pc, 16'h0001);
        chk("stop_busy", 16'(busy), 16'd0);
        chk("stop_idle_req", 16'(bus.imem_req), 16'd0);
        @(negedge clk);
        chk("stop_idle_req2", 16'(bus.imem_req), 16'd0);
        chk("stop_busy2", 16'(busy), 16'd0);
        run = 1'b1;
        @(negedge clk);
        chk("r_addr", bus.imem_addr, 16'h0001);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h6000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("r_busy_exec", 16'(busy), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        chk("r_pc", pc, 16'h0000);
        chk("r_en", 16'(bus.en), 16'd0);
        chk("r_req", 16'(bus.imem_req), 16'd0);
        chk("r_busy", 16'(busy), 16'd0);
        chk("r_op", 16'(bus.op), 16'd0);
        run = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h7000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.exec_done = 1'b1;
        bus.pc_sel = 1'b1;
        bus.pc_target = 16'h0005;
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.pc_sel = 1'b0;
        chk("h_addr", bus.imem_addr, 16'h0005);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hF000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("h_en", 16'(bus.en), 16'd1);
        chk("h_op", 16'(bus.op), 16'hF);
        @(negedge clk);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("h_pc", pc, 16'h0006);
`ifdef FETCH_HALT_EN
        chk("h_halted", 16'(halted), 16'd1);
        chk("h_busy", 16'(busy), 16'd0);
        chk("h_req", 16'(bus.imem_req), 16'd0);
        @(negedge clk);
        @(negedge clk);
        chk("h_hold_req", 16'(bus.imem_req), 16'd0);
        chk("h_hold_halted", 16'(halted), 16'd1);
        chk("h_hold_pc", pc, 16'h0006);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        chk("h_clear", 16'(halted), 16'd0);
`else
        chk("nh_halted", 16'(halted), 16'd0);
        chk("nh_req", 16'(bus.imem_req), 16'd1);
        chk("nh_addr", bus.imem_addr, 16'h0006);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
